ls1u_intc: RTL and testbench
============================

LS1U_INTC -- requirements
Module: ls1u_intc

Interface
REQ-001 Parameters SHALL be: NCH, 8, number of interrupt sources (1..8); DEPTH, 4, nesting stack depth (1..8); CTX_W, 48, width of saved context; AW, 24, vector address width; VSTRIDE, 16, vector spacing in address units.
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low.
REQ-004 src  in  NCH  raw interrupt request lines, synchronous to clk.
REQ-005 irq  out  1  registered request to core INT input.
REQ-006 ivec  out  AW  registered vector address of the current winning channel.
REQ-007 take  in  1  one-cycle pulse: core has vectored to ivec.
REQ-008 ctx_i  in  CTX_W  core context to save on take ({return PC, A2, A1, A0}).
REQ-009 ret  in  1  one-cycle pulse: core executed return-from-interrupt.
REQ-010 ctx_o  out  CTX_W  context popped by the most recent ret, held until the next pop.
REQ-011 in_isr  out  1  high while stack depth > 0.
REQ-012 cfg_addr  in  4  config register byte address.
REQ-013 cfg_wdata / cfg_rdata  in/out  8  config write/read data; rdata combinational from cfg_addr.
REQ-014 cfg_we  in  1  config write strobe, one byte per cycle.

Function
REQ-015 Registers SHALL be: 0x0 ENABLE; 0x1 PENDING (read; write-1-to-clear); 0x2 EDGE (1 = rising-edge, 0 = level); 0x3 PRIO[3:0] channels 0-3 (2 bits each, channel 0 in bits 1:0); 0x4 PRIO channels 4-7; 0x5/0x6/0x7 VBASE L/M/H; 0x8 STATUS {err_under, err_take, 1'b0, depth[3:0], 1'b0}, err bits write-1-to-clear. Bits above NCH read 0; unmapped addresses read 0x00, ignore writes.
REQ-016 Edge channel SHALL set PENDING on src 0->1 (previous sample registered); level channel PENDING SHALL equal src each cycle.
REQ-017 Candidate set SHALL be PENDING & ENABLE; winner = highest PRIO, ties to lowest index.
REQ-018 A winner SHALL be eligible only if depth < DEPTH and (depth == 0 or winner PRIO > PRIO of stack top).
REQ-019 irq and ivec SHALL register eligibility and VBASE + winner*VSTRIDE (modulo 2^AW) each cycle; latency src edge -> irq = 2 cycles.
REQ-020 On take with irq high: push {ctx_i, winner, PRIO}, depth+1, clear PENDING of winner if edge mode; irq SHALL be low the following cycle.
REQ-021 take with irq low SHALL be ignored and set err_take.
REQ-022 On ret with depth > 0: pop top into ctx_o, depth-1. ret with depth 0 SHALL be ignored and set err_under.
REQ-023 Simultaneous take and ret SHALL pop then push (depth unchanged, top replaced, ctx_o updated).
REQ-024 Source edge coincident with a W1C write to the same PENDING bit: set wins.
REQ-025 Config writes SHALL take effect the next cycle; changing PRIO/ENABLE SHALL not alter stack contents.

Reset
REQ-026 Reset SHALL clear ENABLE, PENDING, EDGE, PRIO, VBASE, err bits, depth, edge history; irq=0, ivec=0, ctx_o=0, in_isr=0. Reset mid-ISR discards the stack.

Structure
REQ-027 Register-address constants, STATUS bit positions and parameter defaults SHALL live in shared package ls1u_pkg.
REQ-028 The nesting stack SHALL be sub-module ls1u_ctx_stack (DEPTH entries, push/pop/top, simultaneous pop+push).

Verification
REQ-029 ENABLE=0x01, EDGE=0x01, VBASE=0x001000, pulse src[0] -> irq high 2 cycles later, ivec=0x001000; take -> irq low, in_isr=1, PENDING[0]=0.
REQ-030 PRIO ch2=3, ch5=1, both pending enabled -> ivec=VBASE+0x20; after take, ch5 not raised; after ret, ivec=VBASE+0x50.
REQ-031 Nesting: take ch1 (prio1) with ctx_i=0xAAAA, take ch3 (prio2) with ctx_i=0xBBBB, two rets -> ctx_o=0xBBBB then 0xAAAA, depth 0.
REQ-032 DEPTH=2, three rising priorities pending -> irq stays low after second take until a ret.
REQ-033 ret at depth 0 and take with irq low -> STATUS=0xC0; write 0xC0 -> STATUS=0x00.
REQ-034 Assert rst low during depth 2 -> all outputs zero immediately; after release, no irq until re-configured.

Source files
------------

// File: rtl/ls1u_pkg.sv
// rtl/ls1u_pkg.sv - shared constants and types for the ls1u interrupt controller
package ls1u_pkg;
  localparam int NCH_DEF     = 8;
  localparam int DEPTH_DEF   = 4;
  localparam int CTX_W_DEF   = 48;
  localparam int AW_DEF      = 24;
  localparam int VSTRIDE_DEF = 16;

  localparam int CFG_AW = 4;
  localparam int CFG_DW = 8;
  localparam int PRIO_W = 2;
  localparam int IDX_W  = 3;

  localparam logic [CFG_AW-1:0] A_ENABLE  = 4'h0;
  localparam logic [CFG_AW-1:0] A_PENDING = 4'h1;
  localparam logic [CFG_AW-1:0] A_EDGE    = 4'h2;
  localparam logic [CFG_AW-1:0] A_PRIO_LO = 4'h3;
  localparam logic [CFG_AW-1:0] A_PRIO_HI = 4'h4;
  localparam logic [CFG_AW-1:0] A_VBASE_L = 4'h5;
  localparam logic [CFG_AW-1:0] A_VBASE_M = 4'h6;
  localparam logic [CFG_AW-1:0] A_VBASE_H = 4'h7;
  localparam logic [CFG_AW-1:0] A_STATUS  = 4'h8;

  localparam int ST_ERR_UNDER = 7;
  localparam int ST_ERR_TAKE  = 6;
  localparam int ST_DEPTH_LSB = 1;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [PRIO_W-1:0] prio;
  } tag_t;
endpackage

// File: rtl/ls1u_intc_if.sv
// rtl/ls1u_intc_if.sv - byte-wide configuration register bus
interface ls1u_intc_if;
  import ls1u_pkg::*;
  logic [CFG_AW-1:0] cfg_addr;
  logic [CFG_DW-1:0] cfg_wdata;
  logic [CFG_DW-1:0] cfg_rdata;
  logic              cfg_we;

  modport master (output cfg_addr, cfg_wdata, cfg_we, input cfg_rdata);
  modport slave  (input cfg_addr, cfg_wdata, cfg_we, output cfg_rdata);
endinterface

// File: rtl/ls1u_ctx_stack.sv
// rtl/ls1u_ctx_stack.sv - nesting stack; pop+push in one cycle replaces the top entry
module ls1u_ctx_stack
  import ls1u_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic [3:0]   depth
);
  logic [W-1:0] r_mem [DEPTH];
  logic [3:0]   r_depth;
  logic         w_pop_ok;
  logic         w_push_ok;
  logic [3:0]   w_wr_idx;

  assign w_pop_ok  = pop && (r_depth != 4'd0);
  assign w_push_ok = push && ((r_depth < 4'(DEPTH)) || w_pop_ok);
  assign w_wr_idx  = w_pop_ok ? r_depth - 4'd1 : r_depth;
  assign depth     = r_depth;

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++)
      if (4'(i) == r_depth - 4'd1) top = r_mem[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_depth <= 4'd0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (w_push_ok && 4'(i) == w_wr_idx) r_mem[i] <= din;
      r_depth <= r_depth + 4'(w_push_ok) - 4'(w_pop_ok);
    end
  end
endmodule

// File: rtl/ls1u_intc.sv
// rtl/ls1u_intc.sv - prioritised, nesting interrupt controller with vectored request
module ls1u_intc
  import ls1u_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int CTX_W   = CTX_W_DEF,
  parameter int AW      = AW_DEF,
  parameter int VSTRIDE = VSTRIDE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   src,
  output logic             irq,
  output logic [AW-1:0]    ivec,
  input  logic             take,
  input  logic [CTX_W-1:0] ctx_i,
  input  logic             ret,
  output logic [CTX_W-1:0] ctx_o,
  output logic             in_isr,
  ls1u_intc_if.slave       cfg
);
  localparam int TAG_W = $bits(tag_t);
  localparam int EW    = CTX_W + TAG_W;

  logic [NCH-1:0]    r_en, r_pend, r_edge, r_src_q;
  logic [PRIO_W-1:0] r_prio [NCH];
  logic [23:0]       r_vbase;
  logic              r_err_under, r_err_take;
  logic              r_irq;
  logic [AW-1:0]     r_ivec;
  tag_t              r_win;
  logic [CTX_W-1:0]  r_ctx_o;

  logic [3:0]        w_depth;
  logic [EW-1:0]     w_top;
  tag_t              w_top_tag, w_win;
  logic              w_found, w_elig, w_take_ok, w_pop;
  logic [NCH-1:0]    w_cand, w_w1c, w_tclr, w_pend_nxt;
  logic [15:0]       w_prio_flat;
  logic [7:0]        w_status, w_st_w1c;
  logic [AW-1:0]     w_vec;
  logic              w_unused_top_idx;

  assign w_take_ok        = take & r_irq;
  assign w_pop            = ret & (w_depth != 4'd0);
  assign w_top_tag        = w_top[TAG_W-1:0];
  assign w_unused_top_idx = ^w_top_tag.idx;

  ls1u_ctx_stack #(.DEPTH(DEPTH), .W(EW)) u_stack (
    .clk(clk), .rst(rst), .push(w_take_ok), .pop(ret),
    .din({ctx_i, r_win}), .top(w_top), .depth(w_depth)
  );

  // Strict '>' while scanning upward keeps ties on the lowest index.
  always_comb begin
    w_cand  = r_en & r_pend;
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_cand[i] && (!w_found || r_prio[i] > w_win.prio)) begin
        w_found    = 1'b1;
        w_win.idx  = IDX_W'(i);
        w_win.prio = r_prio[i];
      end
    end
  end

  assign w_elig = w_found && (w_depth < 4'(DEPTH)) &&
                  ((w_depth == 4'd0) || (w_win.prio > w_top_tag.prio));
  assign w_vec  = AW'(r_vbase) + AW'(w_win.idx) * AW'(VSTRIDE);

  always_comb begin
    w_w1c    = '0;
    w_st_w1c = '0;
    w_tclr   = '0;
    if (cfg.cfg_we && cfg.cfg_addr == A_PENDING) w_w1c = cfg.cfg_wdata[NCH-1:0];
    if (cfg.cfg_we && cfg.cfg_addr == A_STATUS) w_st_w1c = cfg.cfg_wdata;
    for (int i = 0; i < NCH; i++)
      if (w_take_ok && IDX_W'(i) == r_win.idx) w_tclr[i] = r_edge[i];
    // A new rising edge outranks any clear in the same cycle.
    w_pend_nxt = (r_edge & ((r_pend & ~w_w1c & ~w_tclr) | (src & ~r_src_q))) |
                 (~r_edge & src);
  end

  always_comb begin
    w_prio_flat = '0;
    for (int i = 0; i < NCH; i++) w_prio_flat[2*i +: 2] = r_prio[i];
    w_status = '0;
    w_status[ST_ERR_UNDER]       = r_err_under;
    w_status[ST_ERR_TAKE]        = r_err_take;
    w_status[ST_DEPTH_LSB +: 4]  = w_depth;
    case (cfg.cfg_addr)
      A_ENABLE:  cfg.cfg_rdata = 8'(r_en);
      A_PENDING: cfg.cfg_rdata = 8'(r_pend);
      A_EDGE:    cfg.cfg_rdata = 8'(r_edge);
      A_PRIO_LO: cfg.cfg_rdata = w_prio_flat[7:0];
      A_PRIO_HI: cfg.cfg_rdata = w_prio_flat[15:8];
      A_VBASE_L: cfg.cfg_rdata = r_vbase[7:0];
      A_VBASE_M: cfg.cfg_rdata = r_vbase[15:8];
      A_VBASE_H: cfg.cfg_rdata = r_vbase[23:16];
      A_STATUS:  cfg.cfg_rdata = w_status;
      default:   cfg.cfg_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en        <= '0;
      r_pend      <= '0;
      r_edge      <= '0;
      r_src_q     <= '0;
      r_vbase     <= '0;
      r_err_under <= 1'b0;
      r_err_take  <= 1'b0;
      r_irq       <= 1'b0;
      r_ivec      <= '0;
      r_win       <= '0;
      r_ctx_o     <= '0;
      for (int i = 0; i < NCH; i++) r_prio[i] <= '0;
    end else begin
      r_src_q     <= src;
      r_pend      <= w_pend_nxt;
      r_irq       <= w_elig & ~w_take_ok;
      r_ivec      <= w_vec;
      r_win       <= w_win;
      r_err_take  <= (r_err_take & ~w_st_w1c[ST_ERR_TAKE]) | (take & ~r_irq);
      r_err_under <= (r_err_under & ~w_st_w1c[ST_ERR_UNDER]) | (ret & (w_depth == 4'd0));
      if (w_pop) r_ctx_o <= w_top[EW-1 -: CTX_W];
      if (cfg.cfg_we) begin
        case (cfg.cfg_addr)
          A_ENABLE:  r_en  <= cfg.cfg_wdata[NCH-1:0];
          A_EDGE:    r_edge <= cfg.cfg_wdata[NCH-1:0];
          A_PRIO_LO: for (int i = 0; i < 4; i++) if (i < NCH) r_prio[i] <= cfg.cfg_wdata[2*i +: 2];
          A_PRIO_HI: for (int i = 0; i < 4; i++) if (i + 4 < NCH) r_prio[i+4] <= cfg.cfg_wdata[2*i +: 2];
          A_VBASE_L: r_vbase[7:0]   <= cfg.cfg_wdata;
          A_VBASE_M: r_vbase[15:8]  <= cfg.cfg_wdata;
          A_VBASE_H: r_vbase[23:16] <= cfg.cfg_wdata;
          default:   ;
        endcase
      end
    end
  end

  assign irq    = r_irq;
  assign ivec   = r_ivec;
  assign ctx_o  = r_ctx_o;
  assign in_isr = (w_depth != 4'd0);
endmodule

// File: tb/tb_ls1u_intc.sv
// tb/tb_ls1u_intc.sv - self-checking bench for ls1u_intc
module tb_ls1u_intc;
  import ls1u_pkg::*;
  localparam int NCH = 8, DEPTH = 2, CTX_W = 48, AW = 24, VSTRIDE = 16;
  localparam int NVEC = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   src;
  logic             irq;
  logic [AW-1:0]    ivec;
  logic             take, ret;
  logic [CTX_W-1:0] ctx_i, ctx_o;
  logic             in_isr;
  logic [7:0]       rdv;

  ls1u_intc_if ifc();

  ls1u_intc #(.NCH(NCH), .DEPTH(DEPTH), .CTX_W(CTX_W), .AW(AW), .VSTRIDE(VSTRIDE)) dut (
    .clk(clk), .rst(rst), .src(src), .irq(irq), .ivec(ivec), .take(take),
    .ctx_i(ctx_i), .ret(ret), .ctx_o(ctx_o), .in_isr(in_isr), .cfg(ifc.slave)
  );

  always #5 clk = ~clk;

  typedef struct { string name; logic [63:0] exp; } sb_t;
  typedef struct { logic [7:0] src; logic [3:0] addr; logic [7:0] wdata; logic we; logic [7:0] exp; } vec_t;
  sb_t  sb_q[$];
  vec_t tbl[NVEC];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input string name, input logic [63:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [63:0] act);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_empty: got 0x%0h expected a queued entry", act);
    end else begin
      e = sb_q.pop_front();
      chk(e.name, act, e.exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    ifc.cfg_addr = a; ifc.cfg_wdata = d; ifc.cfg_we = 1'b1;
    cyc();
    ifc.cfg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d);
    ifc.cfg_addr = a;
    #1;
    d = ifc.cfg_rdata;
  endtask

  task automatic pulse(input logic [7:0] m);
    src = m;
    cyc();
    src = '0;
  endtask

  task automatic do_take(input logic [CTX_W-1:0] c);
    ctx_i = c; take = 1'b1;
    cyc();
    take = 1'b0;
  endtask

  task automatic do_ret();
    ret = 1'b1;
    cyc();
    ret = 1'b0;
  endtask

  task automatic do_reset();
    src = '0; take = 1'b0; ret = 1'b0; ifc.cfg_we = 1'b0;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic set_vbase(input logic [23:0] v);
    wr(A_VBASE_L, v[7:0]);
    wr(A_VBASE_M, v[15:8]);
    wr(A_VBASE_H, v[23:16]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{8'h00, A_ENABLE,  8'hA5, 1'b1, 8'hA5};
    tbl[1]  = '{8'h10, A_PENDING, 8'h00, 1'b0, 8'h10};
    tbl[2]  = '{8'h00, A_PENDING, 8'h00, 1'b0, 8'h00};
    tbl[3]  = '{8'h00, A_EDGE,    8'h3C, 1'b1, 8'h3C};
    tbl[4]  = '{8'h00, A_PRIO_LO, 8'hE4, 1'b1, 8'hE4};
    tbl[5]  = '{8'h00, A_PRIO_HI, 8'h1B, 1'b1, 8'h1B};
    tbl[6]  = '{8'h00, A_VBASE_L, 8'h34, 1'b1, 8'h34};
    tbl[7]  = '{8'h00, A_VBASE_M, 8'h12, 1'b1, 8'h12};
    tbl[8]  = '{8'h00, A_VBASE_H, 8'h56, 1'b1, 8'h56};
    tbl[9]  = '{8'h00, 4'h9,      8'hFF, 1'b1, 8'h00};
    tbl[10] = '{8'h00, 4'hF,      8'h00, 1'b0, 8'h00};
    tbl[11] = '{8'h00, A_STATUS,  8'h00, 1'b0, 8'h00};

    rst = 1'b0; src = '0; take = 1'b0; ret = 1'b0; ctx_i = '0;
    ifc.cfg_addr = '0; ifc.cfg_wdata = '0; ifc.cfg_we = 1'b0;
    cyc(2);
    chk("rst_irq", 64'(irq), 64'h0);
    chk("rst_ivec", 64'(ivec), 64'h0);
    chk("rst_ctx_o", 64'(ctx_o), 64'h0);
    chk("rst_in_isr", 64'(in_isr), 64'h0);
    rd(A_STATUS, rdv);
    chk("rst_status", 64'(rdv), 64'h0);
    rst = 1'b1;
    cyc();

    for (int k = 0; k < NVEC; k++) begin
      src = tbl[k].src;
      ifc.cfg_addr = tbl[k].addr; ifc.cfg_wdata = tbl[k].wdata; ifc.cfg_we = tbl[k].we;
      sb_push($sformatf("vec%0d", k), 64'(tbl[k].exp));
      cyc();
      ifc.cfg_we = 1'b0;
      #1;
      sb_pop(64'(ifc.cfg_rdata));
    end
    src = '0;

    // Single edge channel: latency, vector, take and return.
    do_reset();
    wr(A_ENABLE, 8'h01); wr(A_EDGE, 8'h01); set_vbase(24'h001000);
    pulse(8'h01);
    chk("r29_irq_early", 64'(irq), 64'h0);
    sb_push("r29_irq", 64'h1);
    sb_push("r29_ivec", 64'h1000);
    cyc();
    sb_pop(64'(irq));
    sb_pop(64'(ivec));
    rd(A_PENDING, rdv);
    chk("r29_pend_set", 64'(rdv), 64'h01);
    do_take(48'h1234_5678_9ABC);
    chk("r29_irq_after_take", 64'(irq), 64'h0);
    chk("r29_in_isr", 64'(in_isr), 64'h1);
    rd(A_PENDING, rdv);
    chk("r29_pend_clr", 64'(rdv), 64'h00);
    rd(A_STATUS, rdv);
    chk("r29_status_d1", 64'(rdv), 64'h02);
    do_ret();
    chk("r29_in_isr_ret", 64'(in_isr), 64'h0);
    chk("r29_ctx_o", 64'(ctx_o), 64'h1234_5678_9ABC);

    // Priority selection and blocking of a lower-priority channel.
    do_reset();
    wr(A_ENABLE, 8'h24); wr(A_EDGE, 8'h24); wr(A_PRIO_LO, 8'h30); wr(A_PRIO_HI, 8'h04);
    set_vbase(24'h001000);
    pulse(8'h24);
    sb_push("r30_irq", 64'h1);
    sb_push("r30_ivec_ch2", 64'h1020);
    cyc();
    sb_pop(64'(irq));
    sb_pop(64'(ivec));
    do_take(48'h111);
    cyc(3);
    chk("r30_ch5_blocked", 64'(irq), 64'h0);
    do_ret();
    cyc();
    chk("r30_irq_ch5", 64'(irq), 64'h1);
    chk("r30_ivec_ch5", 64'(ivec), 64'h1050);

    // Two-level nesting, then simultaneous take and return.
    do_reset();
    wr(A_ENABLE, 8'h0A); wr(A_EDGE, 8'h0A); wr(A_PRIO_LO, 8'h84);
    pulse(8'h02); cyc();
    chk("r31_ivec_ch1", 64'(ivec), 64'h10);
    do_take(48'hAAAA);
    pulse(8'h08); cyc();
    chk("r31_irq_ch3", 64'(irq), 64'h1);
    chk("r31_ivec_ch3", 64'(ivec), 64'h30);
    do_take(48'hBBBB);
    rd(A_STATUS, rdv);
    chk("r31_status_d2", 64'(rdv), 64'h04);
    do_ret();
    chk("r31_ctx_o_1", 64'(ctx_o), 64'hBBBB);
    chk("r31_in_isr_1", 64'(in_isr), 64'h1);
    do_ret();
    chk("r31_ctx_o_2", 64'(ctx_o), 64'hAAAA);
    chk("r31_in_isr_2", 64'(in_isr), 64'h0);
    pulse(8'h02); cyc();
    do_take(48'hAAAA);
    pulse(8'h08); cyc();
    chk("r23_irq", 64'(irq), 64'h1);
    ctx_i = 48'hBBBB; take = 1'b1; ret = 1'b1;
    cyc();
    take = 1'b0; ret = 1'b0;
    chk("r23_ctx_o", 64'(ctx_o), 64'hAAAA);
    rd(A_STATUS, rdv);
    chk("r23_depth_same", 64'(rdv), 64'h02);
    do_ret();
    chk("r23_top_replaced", 64'(ctx_o), 64'hBBBB);
    chk("r23_in_isr", 64'(in_isr), 64'h0);

    // Stack full with DEPTH=2: third channel waits for a return.
    do_reset();
    wr(A_ENABLE, 8'h07); wr(A_EDGE, 8'h07); wr(A_PRIO_LO, 8'h39);
    pulse(8'h01); cyc();
    chk("r32_ivec_ch0", 64'(ivec), 64'h00);
    do_take(48'h1);
    pulse(8'h02); cyc();
    chk("r32_ivec_ch1", 64'(ivec), 64'h10);
    do_take(48'h2);
    pulse(8'h04); cyc(3);
    chk("r32_full_no_irq", 64'(irq), 64'h0);
    rd(A_PENDING, rdv);
    chk("r32_pend_ch2", 64'(rdv), 64'h04);
    do_ret();
    cyc();
    chk("r32_irq_after_ret", 64'(irq), 64'h1);
    chk("r32_ivec_ch2", 64'(ivec), 64'h20);

    // Error flags and their write-1-to-clear.
    do_reset();
    do_ret();
    do_take(48'h0);
    rd(A_STATUS, rdv);
    chk("r33_status_err", 64'(rdv), 64'hC0);
    chk("r33_in_isr", 64'(in_isr), 64'h0);
    wr(A_STATUS, 8'hC0);
    rd(A_STATUS, rdv);
    chk("r33_status_clr", 64'(rdv), 64'h00);

    // Rising edge coincident with a W1C write to the same bit.
    do_reset();
    wr(A_EDGE, 8'h01);
    src = 8'h01;
    wr(A_PENDING, 8'h01);
    rd(A_PENDING, rdv);
    chk("r24_set_wins", 64'(rdv), 64'h01);
    wr(A_PENDING, 8'h01);
    rd(A_PENDING, rdv);
    chk("r24_w1c", 64'(rdv), 64'h00);
    src = '0;

    // Asynchronous reset while two levels deep.
    do_reset();
    wr(A_ENABLE, 8'h0A); wr(A_EDGE, 8'h0A); wr(A_PRIO_LO, 8'h84); set_vbase(24'h002000);
    pulse(8'h02); cyc();
    do_take(48'hAAAA);
    pulse(8'h08); cyc();
    do_take(48'hBBBB);
    do_ret();
    pulse(8'h08); cyc();
    do_take(48'hCCCC);
    rd(A_STATUS, rdv);
    chk("r34_pre_depth2", 64'(rdv), 64'h04);
    chk("r34_pre_ctx_o", 64'(ctx_o), 64'hBBBB);
    #2;
    rst = 1'b0;
    #1;
    chk("r34_irq", 64'(irq), 64'h0);
    chk("r34_ivec", 64'(ivec), 64'h0);
    chk("r34_ctx_o", 64'(ctx_o), 64'h0);
    chk("r34_in_isr", 64'(in_isr), 64'h0);
    cyc();
    rst = 1'b1;
    pulse(8'h0A);
    cyc(3);
    chk("r34_no_irq", 64'(irq), 64'h0);
    rd(A_ENABLE, rdv);
    chk("r34_enable_clr", 64'(rdv), 64'h00);

    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
